// File: rtl/player_id_matcher.sv
// Sequential lookup of a player ID in a synchronous ROM of player IDs, reporting found/slot.
// Optional miss counter port is enabled with `define PLAYER_ID_MATCHER_MISS_COUNT_EN.
module player_id_matcher #(
    parameter int                 ADDR_W      = 5,
    parameter int                 DATA_W      = 16,
    parameter int                 ROM_DEPTH   = 32,
    parameter int                 ROM_LATENCY = 1,
    parameter logic [DATA_W-1:0]  EMPTY_CODE  = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] id_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] player_idx
`ifdef PLAYER_ID_MATCHER_MISS_COUNT_EN
    ,
    output logic [7:0]        miss_count
`endif
);

    localparam int                WAIT_W    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(ROM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   id_r;
    logic [WAIT_W-1:0]   wait_cnt_r;

    // Lookup FSM: all outputs are registered; done is high only while in S_DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            id_r       <= '0;
            wait_cnt_r <= '0;
            rom_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            player_idx <= '0;
`ifdef PLAYER_ID_MATCHER_MISS_COUNT_EN
            miss_count <= 8'h00;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        found      <= 1'b0;
                        player_idx <= '0;
                        if (id_in != EMPTY_CODE) begin
                            id_r       <= id_in;
                            rom_addr   <= '0;
                            wait_cnt_r <= '0;
                            busy       <= 1'b1;
                            state_r    <= S_WAIT;
                        end else begin
                            // The empty code can never be a valid player: reject without scanning.
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    if (wait_cnt_r == LAST_WAIT) begin
                        state_r <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (rom_q == id_r) begin
                        found      <= 1'b1;
                        player_idx <= rom_addr;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state_r    <= S_DONE;
                    end else if ((rom_q == EMPTY_CODE) || (rom_addr == LAST_ADDR)) begin
                        found   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        rom_addr   <= rom_addr + ADDR_W'(1);
                        wait_cnt_r <= '0;
                        state_r    <= S_WAIT;
                    end
                end
                S_DONE: begin
                    busy     <= 1'b0;
                    rom_addr <= '0;
                    state_r  <= S_IDLE;
`ifdef PLAYER_ID_MATCHER_MISS_COUNT_EN
                    if (!found && (miss_count != 8'hFF)) begin
                        miss_count <= miss_count + 8'h01;
                    end
`endif
                end
                default: begin
                    busy     <= 1'b0;
                    rom_addr <= '0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_id_matcher.sv
// Bench for player_id_matcher: behavioural 1-cycle ROM, vector table, scoreboard queue.
// Exercises the miss counter too when PLAYER_ID_MATCHER_MISS_COUNT_EN is defined.
module tb_player_id_matcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] id_in;
    logic [4:0]  rom_addr;
    logic [15:0] rom_q;
    logic        busy;
    logic        done;
    logic        found;
    logic [4:0]  player_idx;
`ifdef PLAYER_ID_MATCHER_MISS_COUNT_EN
    logic [7:0]  miss_count;
`endif

    always #5 clk = ~clk;

    logic [15:0] rom_mem [32];
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    player_id_matcher dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .id_in      (id_in),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .player_idx (player_idx)
`ifdef PLAYER_ID_MATCHER_MISS_COUNT_EN
        ,
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        logic        rom_sel;
        logic [15:0] id;
        logic        exp_found;
        int          exp_idx;
        int          exp_lat;
        int          exp_max_addr;
    } vec_t;

    vec_t vecs [8];
    vec_t sb_q [$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ROM A: three players then an empty slot; ROM B: no empty slot, duplicate at 5 and 9.
    task automatic load_rom(input logic sel);
        for (int i = 0; i < 32; i++) begin
            if (!sel) begin
                case (i)
                    0:       rom_mem[i] = 16'h1A2B;
                    1:       rom_mem[i] = 16'h3C4D;
                    2:       rom_mem[i] = 16'h5E6F;
                    3:       rom_mem[i] = 16'h0000;
                    default: rom_mem[i] = 16'hFFFF;
                endcase
            end else begin
                rom_mem[i] = 16'h8000 + 16'(i);
            end
        end
        if (sel) begin
            rom_mem[5] = 16'hBEEF;
            rom_mem[9] = 16'hBEEF;
        end
    endtask

    // Latency = edges after the start edge until done is seen; 0 means the cycle right after start.
    task automatic run_lookup(input vec_t v, input int inj_cyc, input logic [15:0] inj_id);
        vec_t exp;
        int   cnt      = 0;
        int   busy_cnt = 0;
        int   max_addr = 0;
        logic timeout  = 1'b0;
        sb_q.push_back(v);
        id_in = v.id;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        id_in = ~v.id;
        while (!done) begin
            if (busy) busy_cnt++;
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (cnt == inj_cyc) begin
                start = 1'b1;
                id_in = inj_id;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
            if (cnt > 200) begin
                timeout = 1'b1;
                break;
            end
        end
        start = 1'b0;
        exp = sb_q.pop_front();
        if (timeout) begin
            total_cnt++;
            $display("FAIL timeout id=%h: got no done expected done after %0d", exp.id, exp.exp_lat);
        end else begin
            check($sformatf("found id=%h", exp.id), int'(found), int'(exp.exp_found));
            check($sformatf("idx id=%h", exp.id), int'(player_idx), exp.exp_idx);
            check($sformatf("latency id=%h", exp.id), cnt, exp.exp_lat);
            check($sformatf("busy_cycles id=%h", exp.id), busy_cnt, exp.exp_lat);
            check($sformatf("busy_at_done id=%h", exp.id), int'(busy), 0);
            check($sformatf("max_addr id=%h", exp.id), max_addr, exp.exp_max_addr);
            @(posedge clk); #1;
            check($sformatf("done_pulse id=%h", exp.id), int'(done), 0);
            check($sformatf("addr_home id=%h", exp.id), int'(rom_addr), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end

    initial begin
        int   done_seen;
        vec_t v;
        rst   = 1'b1;
        start = 1'b0;
        id_in = 16'h0000;
        load_rom(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", int'(rom_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_found", int'(found), 0);
        check("rst_idx", int'(player_idx), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs[0] = '{1'b0, 16'h5E6F, 1'b1, 2, 6, 2};
        vecs[1] = '{1'b0, 16'h7777, 1'b0, 0, 8, 3};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 0, 0, 0};
        vecs[3] = '{1'b0, 16'h1A2B, 1'b1, 0, 2, 0};
        vecs[4] = '{1'b0, 16'h3C4D, 1'b1, 1, 4, 1};
        vecs[5] = '{1'b1, 16'h1234, 1'b0, 0, 64, 31};
        vecs[6] = '{1'b1, 16'hBEEF, 1'b1, 5, 12, 5};
        vecs[7] = '{1'b1, 16'h801F, 1'b1, 31, 64, 31};

        for (int i = 0; i < 8; i++) begin
            load_rom(vecs[i].rom_sel);
            run_lookup(vecs[i], -1, 16'h0000);
        end

        // A second start for 1A2B mid-scan must not disturb the 5E6F lookup.
        load_rom(1'b0);
        run_lookup(vecs[0], 2, 16'h1A2B);

        // Start while in DONE (after a reject) is ignored.
        id_in = 16'h0000;
        start = 1'b1;
        @(posedge clk); #1;
        check("reject_done", int'(done), 1);
        id_in = 16'h3C4D;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start_busy", int'(busy), 0);
        @(posedge clk); #1;
        check("done_start_busy2", int'(busy), 0);

        // Reset three cycles into a lookup.
        id_in = 16'h5E6F;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_addr", int'(rom_addr), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_found", int'(found), 0);
        check("midrst_idx", int'(player_idx), 0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        check("midrst_no_done", done_seen, 0);
        run_lookup(vecs[4], -1, 16'h0000);

`ifdef PLAYER_ID_MATCHER_MISS_COUNT_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("miss_rst", int'(miss_count), 0);
        run_lookup(vecs[2], -1, 16'h0000);
        v = vecs[1];
        run_lookup(v, -1, 16'h0000);
        check("miss_two", int'(miss_count), 2);
        run_lookup(vecs[3], -1, 16'h0000);
        check("miss_after_hit", int'(miss_count), 2);
        for (int i = 0; i < 298; i++) begin
            id_in = 16'h0000;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
        end
        check("miss_sat", int'(miss_count), 255);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/player_id_matcher.md
Name: player_id_matcher

Overview:
- Lookup engine upstream of the 32x16 player-ID ROM in the IDHandler path.
- On a start pulse, latches a 16-bit entered player ID and sequentially drives the ROM address. It compares each returned word against the latched ID and reports found/not-found plus the matching slot index to game control logic.
- Stops early at the first empty slot.

Parameters:
- ADDR_W, 5: ROM address width
- DATA_W, 16: ROM word / player ID width
- ROM_DEPTH, 32: number of ROM slots scanned, max 2**ADDR_W
- ROM_LATENCY, 1: ROM read latency in clocks (synchronous ROM, address registered inside ROM)
- EMPTY_CODE, 16'h0000: reserved word marking an unused slot / end of table

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- id_in  in  DATA_W  player ID to look up; sampled with start
- rom_addr  out  ADDR_W  registered address to ROM
- rom_q  in  DATA_W  ROM read data
- busy  out  1  high while a lookup is in progress
- done  out  1  one-cycle pulse when the result is valid
- found  out  1  match flag; held until next accepted start
- player_idx  out  ADDR_W  matching slot; 0 on miss; held until next accepted start
- miss_count  out  8  present only with the optional feature

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: rom_addr=0, busy=0, done=0, found=0, player_idx=0, miss_count=0, state=IDLE.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - start=1 and id_in!=EMPTY_CODE: latch id_in into id_reg, rom_addr<=0, wait_cnt<=0, found<=0, player_idx<=0, busy<=1, go to WAIT.
  - start=1 and id_in==EMPTY_CODE: reject. found<=0, player_idx<=0, go to DONE (busy stays 0).
- WAIT: wait_cnt increments each cycle. When wait_cnt==ROM_LATENCY-1, go to CHECK, so rom_q is sampled in CHECK exactly ROM_LATENCY+1 edges after the edge that updated rom_addr.
- CHECK, decided in this order:
  - rom_q==id_reg: found<=1, player_idx<=rom_addr, go to DONE.
  - rom_q==EMPTY_CODE: found<=0, go to DONE (early stop).
  - rom_addr==ROM_DEPTH-1: found<=0, go to DONE (table exhausted; no address wrap).
  - Otherwise: rom_addr<=rom_addr+1, wait_cnt<=0, go to WAIT.
- DONE: done=1 for exactly this one cycle, busy=0, rom_addr<=0, go to IDLE.
- Latency: done asserts (ROM_LATENCY+1)*(k+1) cycles after the start edge, where k is the index of the terminating slot (match, empty, or last). Empty-ID reject: done the cycle after start.
- start while not in IDLE (including DONE) is ignored; id_in changes during a scan have no effect.
- Duplicate IDs in ROM: lowest index wins.
- rst mid-scan: immediate return to reset values; no done pulse; next start begins a fresh scan from slot 0.

Optional Feature:
- Macro: PLAYER_ID_MATCHER_MISS_COUNT_EN.
- Defined: miss_count port exists. It is an 8-bit counter, incremented in DONE when found=0 (including empty-ID rejects) and saturating at 8'hFF. Cleared only by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Bench uses a behavioural ROM with ROM_LATENCY=1: slot0=16'h1A2B, slot1=16'h3C4D, slot2=16'h5E6F, slot3=16'h0000, rest 16'hFFFF.
- Match: start with id_in=16'h5E6F -> rom_addr steps 0,1,2; done pulse 6 cycles after start edge; found=1, player_idx=2; busy high for those 6 cycles.
- Early stop: id_in=16'h7777 -> done 8 cycles after start, found=0, player_idx=0, last rom_addr=3 before returning to 0.
- Full scan: reload ROM with no 16'h0000 and no match, id_in=16'h1234 -> done 64 cycles after start, found=0, rom_addr never wraps past 31.
- Reject and ignore: id_in=16'h0000 -> done the next cycle, found=0, busy never high. A start pulse with id_in=16'h1A2B during a scan for 16'h5E6F is ignored; result remains idx 2.
- Reset mid-scan: assert rst 3 cycles into a lookup -> all outputs at reset values, no done; then start with 16'h3C4D -> found=1, idx=1 after 4 cycles. With the macro defined, miss_count=2 after two misses, and it saturates at 255 after 300 misses.
